// File: rtl/tlb_ptw_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlb_ptw_arbiter_pkg
// Description : Shared types and constants for the TLB miss / PTW arbiter.
//               Widths follow the Sv39 translation scheme.
// Revision    : 1.0 - initial release
// ============================================================================
package tlb_ptw_arbiter_pkg;

  // Sv39 field widths
  localparam int SV39_VPN_W = 27;
  localparam int SV39_PPN_W = 44;
  localparam int PTE_LVL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REFILL = 2'd3
  } ptw_arb_state_t;

  typedef struct packed {
    logic [SV39_VPN_W-1:0] vpn;
  } ptw_req_t;

  typedef struct packed {
    logic [SV39_PPN_W-1:0] ppn;
    logic [PTE_LVL_W-1:0]  level;
    logic                  fault;
  } ptw_resp_t;

  // Width of a requester index; never narrower than one bit
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlb_ptw_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin grant. Picks the first valid requester at or
//               above ptr_i, wrapping to index 0. One-hot output, all zero
//               when en_i is low.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import tlb_ptw_arbiter_pkg::*;
#(
  parameter int REQ_N = 2
) (
  input  logic [REQ_N-1:0]            valid_i,
  input  logic [ptr_width(REQ_N)-1:0] ptr_i,
  input  logic                        en_i,
  output logic [REQ_N-1:0]            grant_o
);

  logic w_found;

  // Two passes: indices from the pointer upward, then the wrapped low part
  always_comb begin
    grant_o = '0;
    w_found = 1'b0;
    for (int i = 0; i < REQ_N; i++) begin
      if (!w_found && valid_i[i] && (i >= int'(ptr_i))) begin
        grant_o[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
    for (int i = 0; i < REQ_N; i++) begin
      if (!w_found && valid_i[i] && (i < int'(ptr_i))) begin
        grant_o[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
    if (!en_i) grant_o = '0;
  end

endmodule
`default_nettype wire

// File: rtl/tlb_ptw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tlb_ptw_arbiter
// Description : Shares one page-table walker between REQ_N TLB miss sources.
//               One walk in flight; sfence mid-walk kills the refill.
//               Optional macro TLB_PTW_ARB_MERGE_EN: requesters missing on
//               the walked VPN are retired alongside the refill.
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_ptw_arbiter
  import tlb_ptw_arbiter_pkg::*;
#(
  parameter int REQ_N = 2,
  parameter int VPN_W = SV39_VPN_W,
  parameter int PPN_W = SV39_PPN_W,
  parameter int LVL_W = PTE_LVL_W
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [REQ_N-1:0]            i_miss_valid,
  input  logic [REQ_N-1:0][VPN_W-1:0] i_miss_vpn,
  output logic [REQ_N-1:0]            o_miss_ready,
  output logic                        o_ptw_req_valid,
  output logic [VPN_W-1:0]            o_ptw_req_vpn,
  input  logic                        i_ptw_req_ready,
  input  logic                        i_ptw_resp_valid,
  input  logic [PPN_W-1:0]            i_ptw_resp_ppn,
  input  logic [LVL_W-1:0]            i_ptw_resp_level,
  input  logic                        i_ptw_resp_fault,
  output logic [REQ_N-1:0]            o_refill_valid,
  output logic [VPN_W-1:0]            o_refill_vpn,
  output logic [PPN_W-1:0]            o_refill_ppn,
  output logic [LVL_W-1:0]            o_refill_level,
  output logic                        o_refill_fault,
  input  logic                        i_sfence_valid,
  output logic                        o_busy
);

  localparam int PTR_W = ptr_width(REQ_N);

  ptw_arb_state_t   state_q;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             kill_q;
  logic [VPN_W-1:0] vpn_q;
  logic [REQ_N-1:0] owner_q;
  logic             ptw_req_valid_q;
  logic [REQ_N-1:0] refill_valid_q;
  logic [PPN_W-1:0] ppn_q;
  logic [LVL_W-1:0] lvl_q;
  logic             fault_q;

  logic [REQ_N-1:0] w_grant;
  logic [VPN_W-1:0] w_grant_vpn;
  logic [REQ_N-1:0] w_merge;
  logic             w_arb_en;

  // No grant outside IDLE, while flushing, or while reset is held
  assign w_arb_en = (state_q == ST_IDLE) && !i_sfence_valid && reset_n;

  rr_arbiter #(.REQ_N(REQ_N)) u_rr_arbiter (
    .valid_i (i_miss_valid),
    .ptr_i   (ptr_q),
    .en_i    (w_arb_en),
    .grant_o (w_grant)
  );

  // Grantee VPN mux and next round-robin pointer (grantee + 1, wrapping)
  always_comb begin
    w_grant_vpn = '0;
    ptr_d       = ptr_q;
    for (int i = 0; i < REQ_N; i++) begin
      if (w_grant[i]) begin
        w_grant_vpn = w_grant_vpn | i_miss_vpn[i];
        ptr_d       = (i == REQ_N - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

`ifdef TLB_PTW_ARB_MERGE_EN
  // Other requesters already missing on the walked VPN share this refill
  always_comb begin
    w_merge = '0;
    if (state_q == ST_REFILL) begin
      for (int i = 0; i < REQ_N; i++) begin
        if (i_miss_valid[i] && !owner_q[i] && (i_miss_vpn[i] == vpn_q))
          w_merge[i] = 1'b1;
      end
    end
  end
`else
  assign w_merge = '0;
`endif

  // Walk sequencing FSM; every data/strobe output is a register here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      ptr_q           <= '0;
      kill_q          <= 1'b0;
      vpn_q           <= '0;
      owner_q         <= '0;
      ptw_req_valid_q <= 1'b0;
      refill_valid_q  <= '0;
      ppn_q           <= '0;
      lvl_q           <= '0;
      fault_q         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|w_grant) begin
            vpn_q           <= w_grant_vpn;
            owner_q         <= w_grant;
            ptr_q           <= ptr_d;
            ptw_req_valid_q <= 1'b1;
            state_q         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (i_ptw_req_ready) begin
            // A flush racing the handshake lets the walk go but poisons it
            ptw_req_valid_q <= 1'b0;
            kill_q          <= i_sfence_valid;
            state_q         <= ST_WAIT;
          end else if (i_sfence_valid) begin
            ptw_req_valid_q <= 1'b0;
            state_q         <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (i_ptw_resp_valid) begin
            if (kill_q || i_sfence_valid) begin
              kill_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              ppn_q          <= i_ptw_resp_ppn;
              lvl_q          <= i_ptw_resp_level;
              fault_q        <= i_ptw_resp_fault;
              refill_valid_q <= owner_q;
              state_q        <= ST_REFILL;
            end
          end else if (i_sfence_valid) begin
            kill_q <= 1'b1;
          end
        end
        ST_REFILL: begin
          refill_valid_q <= '0;
          state_q        <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_miss_ready    = w_grant | w_merge;
  assign o_ptw_req_valid = ptw_req_valid_q;
  assign o_ptw_req_vpn   = vpn_q;
  assign o_refill_valid  = refill_valid_q | w_merge;
  assign o_refill_vpn    = vpn_q;
  assign o_refill_ppn    = ppn_q;
  assign o_refill_level  = lvl_q;
  assign o_refill_fault  = fault_q;
  assign o_busy          = (state_q != ST_IDLE);

endmodule
`default_nettype wire
